foobar_run_ctrl: RTL and testbench

- Run sequencer for the foobar counter datapath. It drives foobar's enable and synchronous clear, and meters enable strobes at a programmable rate.
- Ends a run on a programmed strobe count, a foo/bar count target, or abort.
- Sits between the test/host control logic and the foobar instance. It reports busy/done and the stop cause.

---
 rtl/foobar_pkg.sv | 22 ++
 rtl/foobar_strobe_gen.sv | 34 +++
 rtl/foobar_run_ctrl.sv | 153 +++++++++++++++
 tb/tb_foobar_run_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/foobar_pkg.sv
// Shared types for the foobar run sequencer: FSM states, stop causes and default widths.
package foobar_pkg;

    localparam int DEFAULT_COUNT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_LEN   = 3'd1,
        CAUSE_FOO   = 3'd2,
        CAUSE_BAR   = 3'd3,
        CAUSE_ABORT = 3'd4
    } stop_cause_e;

endpackage

// File: rtl/foobar_strobe_gen.sv
// Enable prescaler: load forces a strobe next cycle and restarts the phase; adv steps the
// phase and strobes every div+1 steps; neither input freezes the phase. Strobe is registered.
module foobar_strobe_gen (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       adv,
    input  logic [7:0] div,
    output logic       strobe
);

    logic [7:0] phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase  <= '0;
            strobe <= 1'b0;
        end else if (load) begin
            phase  <= '0;
            strobe <= 1'b1;
        end else if (adv) begin
            if (phase == div) begin
                phase  <= '0;
                strobe <= 1'b1;
            end else begin
                phase  <= phase + 8'd1;
                strobe <= 1'b0;
            end
        end else begin
            strobe <= 1'b0;
        end
    end

endmodule

// File: rtl/foobar_run_ctrl.sv
// Run sequencer for foobar: clear, metered enable strobes, stop on length/target/abort; all outputs
// registered (one cycle after the deciding edge). Optional pause input under FOOBAR_RUN_CTRL_PAUSE_EN.
module foobar_run_ctrl
    import foobar_pkg::*;
#(
    parameter int TICK_W     = 16,
    parameter int COUNT_W    = DEFAULT_COUNT_W,
    parameter int CLR_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
`ifdef FOOBAR_RUN_CTRL_PAUSE_EN
    input  logic               pause,
`endif
    input  logic [TICK_W-1:0]  run_len,
    input  logic [7:0]         en_div,
    input  logic [COUNT_W-1:0] foo_target,
    input  logic [COUNT_W-1:0] bar_target,
    input  logic [COUNT_W-1:0] count_foo,
    input  logic [COUNT_W-1:0] count_bar,
    output logic               foobar_en,
    output logic               foobar_clr,
    output logic               busy,
    output logic               done,
    output logic [2:0]         stop_cause
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    state_e             state, state_nxt;
    stop_cause_e        cause_q, cause_nxt;
    logic [TICK_W-1:0]  run_len_q;
    logic [TICK_W-1:0]  stb_cnt;
    logic [7:0]         en_div_q;
    logic [COUNT_W-1:0] foo_tgt_q;
    logic [COUNT_W-1:0] bar_tgt_q;
    logic [CLR_W-1:0]   clr_cnt;
    logic               pause_w;
    logic               foo_hit, bar_hit, len_hit;
    logic               stb_load, stb_adv;

`ifdef FOOBAR_RUN_CTRL_PAUSE_EN
    assign pause_w = pause;
`else
    assign pause_w = 1'b0;
`endif

    assign foo_hit = (foo_tgt_q != '0) && (count_foo >= foo_tgt_q);
    assign bar_hit = (bar_tgt_q != '0) && (count_bar >= bar_tgt_q);
    // foobar_en high in RUN marks a strobe this cycle; stb_cnt holds strobes before it
    assign len_hit = foobar_en && ((stb_cnt + TICK_W'(1)) == run_len_q);

    always_comb begin
        state_nxt = state;
        cause_nxt = cause_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CLEAR;
                    cause_nxt = CAUSE_NONE;
                end
            end
            CLEAR: begin
                if (abort) begin
                    state_nxt = DONE;
                    cause_nxt = CAUSE_ABORT;
                end else if (clr_cnt == CLR_LAST) begin
                    if (run_len_q == '0) begin
                        state_nxt = DRAIN;
                        cause_nxt = CAUSE_LEN;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = DONE;
                    cause_nxt = CAUSE_ABORT;
                end else if (foo_hit) begin
                    state_nxt = DRAIN;
                    cause_nxt = CAUSE_FOO;
                end else if (bar_hit) begin
                    state_nxt = DRAIN;
                    cause_nxt = CAUSE_BAR;
                end else if (len_hit) begin
                    state_nxt = DRAIN;
                    cause_nxt = CAUSE_LEN;
                end
            end
            DRAIN: begin
                state_nxt = DONE;
                if (abort) begin
                    cause_nxt = CAUSE_ABORT;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign stb_load = (state != RUN) && (state_nxt == RUN);
    assign stb_adv  = (state == RUN) && (state_nxt == RUN) && !pause_w;

    foobar_strobe_gen u_strobe_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (stb_load),
        .adv    (stb_adv),
        .div    (en_div_q),
        .strobe (foobar_en)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cause_q    <= CAUSE_NONE;
            run_len_q  <= '0;
            en_div_q   <= '0;
            foo_tgt_q  <= '0;
            bar_tgt_q  <= '0;
            stb_cnt    <= '0;
            clr_cnt    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            foobar_clr <= 1'b0;
        end else begin
            state      <= state_nxt;
            cause_q    <= cause_nxt;
            busy       <= (state_nxt != IDLE);
            done       <= (state_nxt == DONE);
            foobar_clr <= (state_nxt == CLEAR);
            clr_cnt    <= (state == CLEAR) ? clr_cnt + CLR_W'(1) : '0;
            if (state == IDLE) begin
                stb_cnt <= '0;
                if (start) begin
                    run_len_q <= run_len;
                    en_div_q  <= en_div;
                    foo_tgt_q <= foo_target;
                    bar_tgt_q <= bar_target;
                end
            end else if ((state == RUN) && foobar_en) begin
                stb_cnt <= stb_cnt + TICK_W'(1);
            end
        end
    end

    assign stop_cause = cause_q;

endmodule

// File: tb/tb_foobar_run_ctrl.sv
// Bench for foobar_run_ctrl: directed table of runs plus random runs against a timeline model.
module tb_foobar_run_ctrl;

    localparam int TICK_W  = 16;
    localparam int COUNT_W = 8;
    localparam int CLR_C   = 2;
    localparam int MAXC    = 80;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [TICK_W-1:0]  run_len = '0;
    logic [7:0]         en_div = '0;
    logic [COUNT_W-1:0] foo_target = '0;
    logic [COUNT_W-1:0] bar_target = '0;
    logic [COUNT_W-1:0] count_foo = '0;
    logic [COUNT_W-1:0] count_bar = '0;
    logic               foobar_en, foobar_clr, busy, done;
    logic [2:0]         stop_cause;
`ifdef FOOBAR_RUN_CTRL_PAUSE_EN
    logic               pause = 1'b0;
`endif

    always #5 clk = ~clk;

    foobar_run_ctrl #(.TICK_W(TICK_W), .COUNT_W(COUNT_W), .CLR_CYCLES(CLR_C)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
`ifdef FOOBAR_RUN_CTRL_PAUSE_EN
        .pause      (pause),
`endif
        .run_len    (run_len),
        .en_div     (en_div),
        .foo_target (foo_target),
        .bar_target (bar_target),
        .count_foo  (count_foo),
        .count_bar  (count_bar),
        .foobar_en  (foobar_en),
        .foobar_clr (foobar_clr),
        .busy       (busy),
        .done       (done),
        .stop_cause (stop_cause)
    );

    // Run description relative to the start cycle (cycle 0); ab/st2 = 0 means none.
    // x_* are the hand-derived outcome: done cycle, cause, strobes issued.
    typedef struct packed {
        int run_len, div, ft, bt, cf_val, cf_cyc, cb_val, cb_cyc, ab, st2;
        int x_dc, x_cause, x_nstb;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    int e_en[MAXC], e_clr[MAXC], e_busy[MAXC], e_done[MAXC], e_cause[MAXC];

    function automatic int foo_at(input vec_t c, input int k);
        return (k >= c.cf_cyc) ? c.cf_val : 0;
    endfunction

    function automatic int bar_at(input vec_t c, input int k);
        return (k >= c.cb_cyc) ? c.cb_val : 0;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Expected timeline: clear window, strobes at fixed spacing from RUN entry,
    // first stop event ends the run; DRAIN then DONE.
    task automatic model(input vec_t c, output int dc);
        int drain, cause, cchg, r0, nstb, k;
        bit stb;
        for (int i = 0; i < MAXC; i++) begin
            e_en[i] = 0; e_clr[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_cause[i] = 0;
        end
        dc = -1; drain = -1; cause = 0; cchg = 0;
        for (int i = 1; i <= CLR_C && dc < 0; i++) begin
            e_clr[i] = 1;
            if (c.ab == i) begin dc = i + 1; cause = 4; cchg = i + 1; end
        end
        if (dc < 0 && c.run_len == 0) begin
            drain = CLR_C + 1; cause = 1;
        end else if (dc < 0) begin
            r0 = CLR_C + 1; nstb = 0; k = r0;
            while (dc < 0 && drain < 0 && k < MAXC - 3) begin
                stb = ((k - r0) % (c.div + 1) == 0) && (nstb < c.run_len);
                e_en[k] = int'(stb);
                if (stb) nstb++;
                if (c.ab == k) begin dc = k + 1; cause = 4; cchg = k + 1; end
                else if (c.ft != 0 && foo_at(c, k) >= c.ft) begin drain = k + 1; cause = 2; end
                else if (c.bt != 0 && bar_at(c, k) >= c.bt) begin drain = k + 1; cause = 3; end
                else if (stb && nstb == c.run_len) begin drain = k + 1; cause = 1; end
                k++;
            end
        end
        if (drain >= 0) begin cchg = drain; dc = drain + 1; end
        for (int i = 1; i < MAXC; i++) begin
            e_busy[i]  = int'(i <= dc);
            e_done[i]  = int'(i == dc);
            e_cause[i] = (i >= cchg) ? cause : 0;
            if (drain >= 0 && c.ab == drain && i >= dc) e_cause[i] = 4;
        end
    endtask

    task automatic run_one(input vec_t c, input string nm, output int odc, output int ocause,
                           output int onstb);
        int dc;
        logic [6:0] got, ex, mask;
        model(c, dc);
        odc = -1; ocause = -1; onstb = 0;
        for (int k = 0; k <= dc + 1; k++) begin
            @(posedge clk); #1;
            got  = {foobar_en, foobar_clr, busy, done, stop_cause};
            ex   = {e_en[k][0], e_clr[k][0], e_busy[k][0], e_done[k][0], e_cause[k][2:0]};
            mask = (k == 0) ? 7'b1111000 : 7'b1111111;
            n_vec++;
            if ((got & mask) != (ex & mask)) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got en,clr,busy,done,cause=%b required %b",
                         nm, k, got & mask, ex & mask);
            end
            if (done && odc < 0) begin odc = k; ocause = int'(stop_cause); end
            if (foobar_en) onstb++;
            start      = (k == 0) || (k == c.st2);
            abort      = (k == c.ab);
            run_len    = TICK_W'(c.run_len);
            en_div     = 8'(c.div);
            foo_target = COUNT_W'(c.ft);
            bar_target = COUNT_W'(c.bt);
            count_foo  = COUNT_W'(foo_at(c, k));
            count_bar  = COUNT_W'(bar_at(c, k));
        end
        start = 1'b0; abort = 1'b0; count_foo = '0; count_bar = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        vec_t c;
        int dc, ocause, onstb;
        string nm;

        //           len div ft bt cfv cfc cbv cbc ab st2   dc cause nstb
        tbl[0] = '{  5,  0, 0, 0,  0,  0,  0,  0, 0,  0,    9, 1, 5};
        tbl[1] = '{  3,  3, 0, 0,  0,  0,  0,  0, 0,  0,   13, 1, 3};
        tbl[2] = '{ 10,  0, 4, 4,  4,  5,  4,  5, 0,  0,    7, 2, 3};
        tbl[3] = '{ 10,  1, 0, 0,  0,  0,  0,  0, 6,  4,    7, 4, 2};
        tbl[4] = '{  0,  0, 0, 0,  0,  0,  0,  0, 0,  0,    4, 1, 0};
        tbl[5] = '{ 10,  0, 5, 3,  2,  3,  3,  4, 0,  0,    6, 3, 2};
        tbl[6] = '{  4,  0, 0, 0,  0,  0,  0,  0, 1,  0,    2, 4, 0};
        tbl[7] = '{  2,  0, 0, 0,  0,  0,  0,  0, 5,  0,    6, 4, 2};
        tbl[8] = '{  2,  0, 1, 0,  1,  4,  0,  0, 0,  0,    6, 2, 2};
        tbl[9] = '{  4,  2, 0, 9,  0,  0,  8,  3, 0,  0,   14, 1, 4};

        #12;
        chk("reset_outputs", int'({foobar_en, foobar_clr, busy, done, stop_cause}), 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", int'({foobar_en, foobar_clr, busy, done, stop_cause}), 0);

        for (int i = 0; i < 10; i++) begin
            nm = $sformatf("tbl%0d", i);
            run_one(tbl[i], nm, dc, ocause, onstb);
            chk({nm, "_done_cyc"}, dc, tbl[i].x_dc);
            chk({nm, "_cause"}, ocause, tbl[i].x_cause);
            chk({nm, "_strobes"}, onstb, tbl[i].x_nstb);
            @(posedge clk);
        end

        for (int r = 0; r < 30; r++) begin
            c = '0;
            c.run_len = $urandom_range(0, 6);
            c.div     = $urandom_range(0, 3);
            c.ft      = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0;
            c.bt      = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 10) : 0;
            c.cf_val  = $urandom_range(0, 12);
            c.cf_cyc  = $urandom_range(1, 20);
            c.cb_val  = $urandom_range(0, 12);
            c.cb_cyc  = $urandom_range(1, 20);
            c.ab      = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 25) : 0;
            model(c, dc);
            c.st2     = ($urandom_range(0, 1) == 1) ? $urandom_range(1, dc) : 0;
            run_one(c, $sformatf("rnd%0d", r), dc, ocause, onstb);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // asynchronous reset in the middle of a run
        @(posedge clk); #1;
        run_len = 16'd10; en_div = 8'd0; foo_target = '0; bar_target = '0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_running", int'({foobar_en, foobar_clr, busy, done, stop_cause}), 7'b1010000);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_outputs", int'({foobar_en, foobar_clr, busy, done, stop_cause}), 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("after_rst_idle", int'({foobar_en, foobar_clr, busy, done, stop_cause}), 0);
        run_one(tbl[0], "post_rst_run", dc, ocause, onstb);
        chk("post_rst_done_cyc", dc, tbl[0].x_dc);
        chk("post_rst_cause", ocause, tbl[0].x_cause);
        chk("post_rst_strobes", onstb, tbl[0].x_nstb);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
